decoder_stage: RTL and testbench

Buffered, handshaked RV32I instruction-decode stage: the parametrised successor to the single-register decoder. Fetched instructions are queued in a DEPTH-entry FIFO, decoded from the queue head and presented in a registered output slot under a valid/ready handshake to the execute stage. Illegal encodings do not reach execute; they raise a held interrupt request that is released by IntAck.

---
 rtl/decoder_stage_if.sv | 40 ++++
 rtl/decoder_stage.sv | 210 +++++++++++++++++++++
 tb/tb_decoder_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_stage_if.sv
// decoder_stage_if: fetch-side, execute-side and trap signals of decoder_stage.
// master = fetch/execute/trap-handler side, slave = the decode stage.
// Ports: InstValid/InstReady/DataInst/InstPc (fetch), OutValid/OutReady and
// decoded fields (execute), Int/IntData/IntAck (trap), Level (occupancy).
interface decoder_stage_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    logic                         InstValid;
    logic                         InstReady;
    logic [31:0]                  DataInst;
    logic [PC_W-1:0]              InstPc;
    logic                         OutValid;
    logic                         OutReady;
    logic [4:0]                   SelRS1;
    logic [4:0]                   SelRS2;
    logic [4:0]                   SelD;
    logic [31:0]                  DataIMM;
    logic                         RegDwe;
    logic [6:0]                   AluOp;
    logic [15:0]                  AluFunc;
    logic [4:0]                   MemOp;
    logic [PC_W-1:0]              OutPc;
    logic                         Int;
    logic [31:0]                  IntData;
    logic                         IntAck;
    logic [$clog2(DEPTH+1)-1:0]   Level;

    modport master (
        output InstValid, DataInst, InstPc, OutReady, IntAck,
        input  InstReady, OutValid, SelRS1, SelRS2, SelD, DataIMM,
        input  RegDwe, AluOp, AluFunc, MemOp, OutPc, Int, IntData, Level
    );

    modport slave (
        input  InstValid, DataInst, InstPc, OutReady, IntAck,
        output InstReady, OutValid, SelRS1, SelRS2, SelD, DataIMM,
        output RegDwe, AluOp, AluFunc, MemOp, OutPc, Int, IntData, Level
    );
endinterface

// File: rtl/decoder_stage.sv
// decoder_stage: queued RV32I decode stage with a registered output slot and
// an illegal-instruction trap held until IntAck.
// Ports: Clk, Rst (sync, active high), En (advance), Flush, bus (slave side).
// Optional macro DECODER_RVM_EN: accept OP funct7=0x01 (MUL..REMU) as legal.
module decoder_stage #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Flush,
    decoder_stage_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic {RUN, TRAP} state_t;

    state_t            state;
    logic [31:0]       mem_inst [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     count;

    logic              out_valid, reg_dwe, int_req;
    logic [4:0]        sel_rs1, sel_rs2, sel_d, mem_op;
    logic [31:0]       data_imm, int_data;
    logic [6:0]        alu_op;
    logic [15:0]       alu_func;
    logic [PC_W-1:0]   out_pc;

    logic              full, empty, push, pop, discard, slot_free;
    logic [31:0]       hi;
    logic [6:0]        opc, f7;
    logic [2:0]        f3;
    logic              legal, dwe;
    logic [31:0]       imm;
    logic [4:0]        mop;

    assign full      = (count == LW'(DEPTH));
    assign empty     = (count == '0);
    assign hi        = mem_inst[rd_ptr];
    assign slot_free = !out_valid || bus.OutReady;
    // No pass-through: a full queue refuses the push even if it pops.
    assign push    = En && !Flush && bus.InstValid && !full;
    assign pop     = En && !Flush && (state == RUN) && !empty
                     && legal && slot_free;
    assign discard = En && !Flush && (state == TRAP) && bus.IntAck;

    assign opc = hi[6:0];
    assign f3  = hi[14:12];
    assign f7  = hi[31:25];

    always_comb begin
        legal = 1'b0;
        dwe   = 1'b0;
        imm   = {{20{hi[31]}}, hi[31:20]};
        mop   = '0;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1;
                dwe   = 1'b1;
                imm   = {hi[31:12], 12'b0};
            end
            OPC_JAL: begin
                legal = 1'b1;
                dwe   = 1'b1;
                imm   = {{11{hi[31]}}, hi[31], hi[19:12],
                         hi[20], hi[30:21], 1'b0};
            end
            OPC_JALR: begin
                legal = (f3 == 3'd0);
                dwe   = 1'b1;
            end
            OPC_BRANCH: begin
                legal = (f3 != 3'd2) && (f3 != 3'd3);
                imm   = {{19{hi[31]}}, hi[31], hi[7],
                         hi[30:25], hi[11:8], 1'b0};
            end
            OPC_LOAD: begin
                legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                dwe   = 1'b1;
                mop   = {2'b10, f3};
            end
            OPC_STORE: begin
                legal = (f3 <= 3'd2);
                imm   = {{20{hi[31]}}, hi[31:25], hi[11:7]};
                mop   = {2'b11, f3};
            end
            OPC_OPIMM: begin
                dwe = 1'b1;
                if (f3 == 3'd1)
                    legal = (f7 == 7'h00);
                else if (f3 == 3'd5)
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                else
                    legal = 1'b1;
            end
            OPC_OP: begin
                dwe = 1'b1;
                imm = '0;
                if (f7 == 7'h00)
                    legal = 1'b1;
                else if (f7 == 7'h20)
                    legal = (f3 == 3'd0) || (f3 == 3'd5);
`ifdef DECODER_RVM_EN
                else if (f7 == 7'h01)
                    legal = 1'b1;
`endif
            end
            OPC_FENCE, OPC_SYSTEM: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        if (hi[11:7] == 5'd0)
            dwe = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= bus.DataInst;
            mem_pc[wr_ptr]   <= bus.InstPc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            state     <= RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            sel_rs1   <= '0;
            sel_rs2   <= '0;
            sel_d     <= '0;
            data_imm  <= '0;
            reg_dwe   <= 1'b0;
            alu_op    <= '0;
            alu_func  <= '0;
            mem_op    <= '0;
            out_pc    <= '0;
            int_req   <= 1'b0;
            int_data  <= '0;
        end else if (En) begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop || discard)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(push) - LW'(pop || discard);
            if (pop) begin
                out_valid <= 1'b1;
                sel_rs1   <= hi[19:15];
                sel_rs2   <= hi[24:20];
                sel_d     <= hi[11:7];
                data_imm  <= imm;
                reg_dwe   <= dwe;
                alu_op    <= opc;
                alu_func  <= {6'b0, f7, f3};
                mem_op    <= mop;
                out_pc    <= mem_pc[rd_ptr];
            end else if (bus.OutReady) begin
                out_valid <= 1'b0;
            end
            case (state)
                RUN: begin
                    if (!empty && !legal) begin
                        state    <= TRAP;
                        int_req  <= 1'b1;
                        int_data <= hi;
                    end
                end
                TRAP: begin
                    if (bus.IntAck) begin
                        state    <= RUN;
                        int_req  <= 1'b0;
                        int_data <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.InstReady = !full;
    assign bus.OutValid  = out_valid;
    assign bus.SelRS1    = sel_rs1;
    assign bus.SelRS2    = sel_rs2;
    assign bus.SelD      = sel_d;
    assign bus.DataIMM   = data_imm;
    assign bus.RegDwe    = reg_dwe;
    assign bus.AluOp     = alu_op;
    assign bus.AluFunc   = alu_func;
    assign bus.MemOp     = mem_op;
    assign bus.OutPc     = out_pc;
    assign bus.Int       = int_req;
    assign bus.IntData   = int_data;
    assign bus.Level     = count;
endmodule

// File: tb/tb_decoder_stage.sv
// tb_decoder_stage: directed checks of decoder_stage (DEPTH=4, PC_W=32).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_decoder_stage;
    logic clk = 1'b0;
    logic rst, en, flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    decoder_stage_if #(.DEPTH(4), .PC_W(32)) bus ();

    decoder_stage #(.DEPTH(4), .PC_W(32)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .En    (en),
        .Flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd,
                                         input logic [11:0] im);
        return {im, 5'd0, 3'd0, rd, 7'h13};
    endfunction

    // Push one word, let it reach the slot, check it, then drain it.
    task automatic run_one(input logic [31:0] w, input logic [31:0] pc,
                           input logic [31:0] e_imm, input logic e_dwe,
                           input logic [4:0] e_mop, input string tag);
        bus.OutReady  = 1'b1;
        bus.InstValid = 1'b1;
        bus.DataInst  = w;
        bus.InstPc    = pc;
        tick();
        bus.InstValid = 1'b0;
        tick();
        chk({tag, "_valid"}, bus.OutValid, 1);
        chk({tag, "_imm"}, bus.DataIMM, e_imm);
        chk({tag, "_dwe"}, bus.RegDwe, e_dwe);
        chk({tag, "_memop"}, bus.MemOp, e_mop);
        chk({tag, "_pc"}, bus.OutPc, pc);
        tick();
        chk({tag, "_drained"}, bus.OutValid, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        bus.InstValid = 1'b0; bus.DataInst = '0; bus.InstPc = '0;
        bus.OutReady = 1'b0; bus.IntAck = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_level", bus.Level, 0);
        chk("rst_ready", bus.InstReady, 1);
        chk("rst_valid", bus.OutValid, 0);
        chk("rst_int", bus.Int, 0);
        chk("rst_intdata", bus.IntData, 0);
        chk("rst_seld", bus.SelD, 0);
        chk("rst_imm", bus.DataIMM, 0);

        // En=0 freezes the queue.
        en = 1'b0;
        bus.InstValid = 1'b1;
        bus.DataInst = 32'h00500093;
        tick();
        chk("en0_level", bus.Level, 0);
        bus.InstValid = 1'b0;
        en = 1'b1;

        // ADDI x1,x0,5 latency: visible after the 2nd edge.
        bus.OutReady = 1'b1;
        bus.InstValid = 1'b1;
        bus.DataInst = 32'h00500093;
        bus.InstPc = 32'h100;
        tick();
        bus.InstValid = 1'b0;
        chk("lat_v1", bus.OutValid, 0);
        chk("lat_lvl1", bus.Level, 1);
        tick();
        chk("lat_v2", bus.OutValid, 1);
        chk("addi_seld", bus.SelD, 1);
        chk("addi_imm", bus.DataIMM, 5);
        chk("addi_dwe", bus.RegDwe, 1);
        chk("addi_op", bus.AluOp, 32'h13);
        chk("addi_func", bus.AluFunc, 0);
        chk("addi_pc", bus.OutPc, 32'h100);
        chk("addi_lvl", bus.Level, 0);
        tick();
        chk("addi_drain", bus.OutValid, 0);

        run_one(32'h00000013, 32'h104, 0, 1'b0, 5'd0, "nop");
        run_one(32'h00112223, 32'h108, 4, 1'b0, 5'b11010, "sw");
        chk("sw_rs1", bus.SelRS1, 2);
        chk("sw_rs2", bus.SelRS2, 1);
        run_one(32'hFFF00093, 32'h10C, 32'hFFFFFFFF, 1'b1, 5'd0, "addim1");
        run_one(32'h123452B7, 32'h110, 32'h12345000, 1'b1, 5'd0, "lui");
        run_one(32'hFE000EE3, 32'h114, 32'hFFFFFFFC, 1'b0, 5'd0, "beq");
        run_one(32'h00412183, 32'h118, 4, 1'b1, 5'b10010, "lw");

        // Backpressure: 5 pushes with OutReady=0 fill slot + queue.
        bus.OutReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.InstValid = 1'b1;
            bus.DataInst = addi(5'(i + 1), 12'(i + 1));
            bus.InstPc = 32'h200 + 32'(4 * i);
            tick();
        end
        bus.DataInst = addi(5'd6, 12'd6);
        bus.InstPc = 32'h214;
        chk("bp_level", bus.Level, 4);
        chk("bp_ready", bus.InstReady, 0);
        chk("bp_valid", bus.OutValid, 1);
        chk("bp_seld", bus.SelD, 1);
        tick();
        chk("bp_stall_lvl", bus.Level, 4);
        chk("bp_stable", bus.SelD, 1);
        bus.OutReady = 1'b1;
        tick();
        chk("bp_nopass_lvl", bus.Level, 3);
        chk("bp_seld2", bus.SelD, 2);
        chk("bp_ready2", bus.InstReady, 1);
        tick();
        bus.InstValid = 1'b0;
        chk("bp_push6_lvl", bus.Level, 3);
        chk("bp_seld3", bus.SelD, 3);
        tick();
        tick();
        tick();
        chk("bp_seld6", bus.SelD, 6);
        chk("bp_pc6", bus.OutPc, 32'h214);
        chk("bp_empty", bus.Level, 0);
        tick();
        chk("bp_drain", bus.OutValid, 0);

        // Illegal word followed by ADD.
        bus.InstValid = 1'b1;
        bus.DataInst = 32'hFFFFFFFF;
        tick();
        chk("trap_int0", bus.Int, 0);
        bus.DataInst = 32'h002081B3;
        tick();
        bus.InstValid = 1'b0;
        chk("trap_int1", bus.Int, 1);
        chk("trap_data", bus.IntData, 32'hFFFFFFFF);
        chk("trap_lvl", bus.Level, 2);
        chk("trap_valid", bus.OutValid, 0);
        tick();
        tick();
        chk("trap_hold", bus.Int, 1);
        chk("trap_hold_lvl", bus.Level, 2);
        bus.IntAck = 1'b1;
        tick();
        bus.IntAck = 1'b0;
        chk("ack_int", bus.Int, 0);
        chk("ack_data", bus.IntData, 0);
        chk("ack_lvl", bus.Level, 1);
        tick();
        chk("add_valid", bus.OutValid, 1);
        chk("add_seld", bus.SelD, 3);
        chk("add_rs1", bus.SelRS1, 1);
        chk("add_rs2", bus.SelRS2, 2);
        chk("add_op", bus.AluOp, 32'h33);
        chk("add_imm", bus.DataIMM, 0);
        tick();

        // Flush with Level=3 and a pending trap.
        bus.OutReady = 1'b0;
        bus.InstValid = 1'b1;
        bus.DataInst = addi(5'd1, 12'd1);
        tick();
        bus.DataInst = 32'hFFFFFFFF;
        tick();
        bus.DataInst = addi(5'd2, 12'd2);
        tick();
        bus.DataInst = addi(5'd3, 12'd3);
        tick();
        chk("fl_pre_lvl", bus.Level, 3);
        chk("fl_pre_int", bus.Int, 1);
        chk("fl_pre_valid", bus.OutValid, 1);
        flush = 1'b1;
        bus.IntAck = 1'b1;
        tick();
        flush = 1'b0;
        bus.IntAck = 1'b0;
        bus.InstValid = 1'b0;
        chk("fl_lvl", bus.Level, 0);
        chk("fl_int", bus.Int, 0);
        chk("fl_valid", bus.OutValid, 0);
        chk("fl_ready", bus.InstReady, 1);
        chk("fl_intdata", bus.IntData, 0);

        // MUL x3,x1,x2.
        bus.OutReady = 1'b1;
        bus.InstValid = 1'b1;
        bus.DataInst = 32'h022081B3;
        tick();
        bus.InstValid = 1'b0;
        tick();
`ifdef DECODER_RVM_EN
        chk("mul_valid", bus.OutValid, 1);
        chk("mul_func", bus.AluFunc, 32'h0008);
        chk("mul_seld", bus.SelD, 3);
        chk("mul_int", bus.Int, 0);
        tick();
`else
        chk("mul_int", bus.Int, 1);
        chk("mul_data", bus.IntData, 32'h022081B3);
        chk("mul_valid", bus.OutValid, 0);
        bus.IntAck = 1'b1;
        tick();
        bus.IntAck = 1'b0;
        chk("mul_ack_int", bus.Int, 0);
        chk("mul_ack_lvl", bus.Level, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
